// File: rtl/byte_nibble_tx_pkg.sv
// Shared types and control-bit positions for the byte-to-nibble transmitter.
package byte_nibble_tx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2
   } state_t;

   // Bit positions within the per-byte ctrl field
   localparam int CTRL_HI_FIRST  = 0;
   localparam int CTRL_DROP_ZERO = 1;

endpackage

// File: rtl/byte_nibble_tx_fifo.sv
// Small synchronous FIFO with full/empty flags; a push at full is refused even
// when a pop happens in the same cycle.
module byte_nibble_tx_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy update; depth is a power of two so pointers wrap naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/byte_nibble_tx.sv
// Byte-to-nibble transmitter: buffers bytes in a FIFO and emits each as one
// or two nibbles on a valid/ready link, counting completed bytes.
module byte_nibble_tx
   import byte_nibble_tx_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int NIB_W      = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic [3:0]        ctrl,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [NIB_W-1:0]  nib_out,
   output logic              nib_valid,
   input  logic              nib_ready,
   output logic              nib_last,
   output logic              busy,
   output logic [7:0]        byte_count
);

   localparam int EW = DATA_W + 2;

   state_t          state;
   logic [EW-1:0]   hold;
   logic [EW-1:0]   fifo_dout;
   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic            xfer;
   logic            byte_done;
   logic            unused_ctrl;

   // Entry layout is {ctrl[1:0], data}
   function automatic logic [NIB_W-1:0] first_nib(input logic [EW-1:0] e);
      return e[DATA_W+CTRL_HI_FIRST] ? e[DATA_W-1:NIB_W] : e[NIB_W-1:0];
   endfunction

   function automatic logic [NIB_W-1:0] second_nib(input logic [EW-1:0] e);
      return e[DATA_W+CTRL_HI_FIRST] ? e[NIB_W-1:0] : e[DATA_W-1:NIB_W];
   endfunction

   function automatic logic drops_second(input logic [EW-1:0] e);
      return e[DATA_W+CTRL_DROP_ZERO] && (second_nib(e) == '0);
   endfunction

   assign unused_ctrl = ^ctrl[3:2];
   assign in_ready    = !fifo_full && !rst;
   assign push        = in_valid && in_ready;
   assign xfer        = nib_valid && nib_ready;
   assign byte_done   = xfer && ((state == SECOND) || ((state == FIRST) && drops_second(hold)));
   assign pop         = !fifo_empty && ((state == IDLE) || byte_done);
   assign busy        = (state != IDLE) || !fifo_empty;

   byte_nibble_tx_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   ({ctrl[1:0], data_in}),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // FSM with registered nibble outputs; a pop on byte completion reloads with no bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hold       <= '0;
         nib_out    <= '0;
         nib_valid  <= 1'b0;
         nib_last   <= 1'b0;
         byte_count <= 8'd0;
      end else begin
         if (byte_done) begin
            byte_count <= byte_count + 8'd1;
         end
         if (pop) begin
            state     <= FIRST;
            hold      <= fifo_dout;
            nib_out   <= first_nib(fifo_dout);
            nib_valid <= 1'b1;
            nib_last  <= drops_second(fifo_dout);
         end else if (byte_done) begin
            state     <= IDLE;
            nib_valid <= 1'b0;
            nib_last  <= 1'b0;
         end else if ((state == FIRST) && xfer) begin
            state    <= SECOND;
            nib_out  <= second_nib(hold);
            nib_last <= 1'b1;
         end else begin
            state <= state;
         end
      end
   end

endmodule

// File: tb/tb_byte_nibble_tx.sv
// Scoreboard bench for byte_nibble_tx: the driver pushes expected nibbles on
// accept, a negedge monitor pops and compares on every transfer.
module tb_byte_nibble_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = 8'd0;
   logic [3:0] ctrl = 4'd0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] nib_out;
   logic       nib_valid;
   logic       nib_ready = 1'b0;
   logic       nib_last;
   logic       busy;
   logic [7:0] byte_count;

   int n_cmp = 0;
   int n_fail = 0;

   logic [4:0] sb [$];
   int         exp_count = 0;
   bit         rand_mode = 1'b0;
   bit         no_bubble = 1'b0;
   bit         armed = 1'b0;
   bit         stall_v = 1'b0;
   logic [3:0] stall_nib = 4'd0;
   logic       stall_last = 1'b0;

   byte_nibble_tx dut (
      .clk(clk), .rst(rst), .data_in(data_in), .ctrl(ctrl), .in_valid(in_valid),
      .in_ready(in_ready), .nib_out(nib_out), .nib_valid(nib_valid),
      .nib_ready(nib_ready), .nib_last(nib_last), .busy(busy), .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_mode) nib_ready = 1'($urandom_range(0, 1));
   endtask

   // Reference model: the byte's nibbles in transmission order
   task automatic model_push(input logic [7:0] d, input logic [3:0] c);
      logic [3:0] lo, hi, f, s;
      lo = d % 16;
      hi = d / 16;
      f  = c[0] ? hi : lo;
      s  = c[0] ? lo : hi;
      if (c[1] && s == 4'd0) begin
         sb.push_back({f, 1'b1});
      end else begin
         sb.push_back({f, 1'b0});
         sb.push_back({s, 1'b1});
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic [3:0] c);
      bit acc;
      acc = 1'b0;
      data_in  = d;
      ctrl     = c;
      in_valid = 1'b1;
      for (int t = 0; t < 300 && !acc; t++) begin
         @(negedge clk);
         if (in_ready && !rst) begin
            model_push(d, c);
            acc = 1'b1;
         end
         tick();
      end
      in_valid = 1'b0;
      if (!acc) check("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() > 0 && t < 3000) begin
         tick();
         t++;
      end
      check("drain_empty", sb.size(), 0);
      tick();
   endtask

   // Monitor: compares every transfer with the scoreboard and checks stalls, bubbles, count
   always @(negedge clk) begin
      if (rst) begin
         exp_count = 0;
         stall_v   = 1'b0;
         armed     = 1'b0;
      end else begin
         check("byte_count", byte_count, exp_count % 256);
         if (stall_v) begin
            check("stall_valid", nib_valid, 1);
            check("stall_data", {nib_out, nib_last}, {stall_nib, stall_last});
         end
         if (no_bubble && armed && sb.size() > 0) check("no_bubble", nib_valid, 1);
         if (nib_valid && nib_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_nibble", {nib_out, nib_last}, 0);
               if ({nib_out, nib_last} == 5'd0) check("unexpected_nibble_v", 1, 0);
            end else begin
               logic [4:0] e;
               e = sb.pop_front();
               check("nibble", {nib_out, nib_last}, e);
               if (e[0]) exp_count++;
            end
            if (no_bubble) armed = 1'b1;
         end
         stall_v    = nib_valid && !nib_ready;
         stall_nib  = nib_out;
         stall_last = nib_last;
         if (!no_bubble) armed = 1'b0;
      end
   end

   initial begin
      // 1: reset state
      tick();
      tick();
      check("rst_nib_valid", nib_valid, 0);
      check("rst_nib_out", nib_out, 0);
      check("rst_nib_last", nib_last, 0);
      check("rst_byte_count", byte_count, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_busy", busy, 0);

      // 2: single byte, 2-cycle first-nibble latency
      nib_ready = 1'b1;
      send_byte(8'hA5, 4'd0);
      check("lat_n", nib_valid, 0);
      tick();
      check("lat_n1_valid", nib_valid, 1);
      check("lat_n1_data", nib_out, 5);
      drain();
      check("count_after_a5", byte_count, 1);

      // 3: ordering and zero-drop control
      send_byte(8'h3C, 4'd1);
      send_byte(8'h07, 4'd2);
      send_byte(8'h17, 4'd2);
      drain();

      // 4: backpressure fills the FIFO, then a bubble-free drain
      nib_ready = 1'b0;
      send_byte(8'h11, 4'd0);
      send_byte(8'h22, 4'd0);
      send_byte(8'h33, 4'd0);
      fork
         send_byte(8'h44, 4'd0);
         begin
            tick();
            tick();
            check("full_in_ready", in_ready, 0);
            check("held_valid", nib_valid, 1);
            check("held_nib", nib_out, 1);
            nib_ready = 1'b1;
            no_bubble = 1'b1;
         end
      join
      drain();
      no_bubble = 1'b0;

      // 6: reset while in SECOND with two bytes queued
      nib_ready = 1'b0;
      send_byte(8'h81, 4'd0);
      send_byte(8'h82, 4'd0);
      send_byte(8'h83, 4'd0);
      nib_ready = 1'b1;
      tick();
      nib_ready = 1'b0;
      check("second_last", nib_last, 1);
      rst = 1'b1;
      sb.delete();
      tick();
      check("midrst_valid", nib_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", in_ready, 0);
      rst = 1'b0;
      nib_ready = 1'b1;
      repeat (10) tick();
      check("after_rst_busy", busy, 0);

      // 5: 256 back-to-back bytes wrap the counter
      no_bubble = 1'b1;
      for (int i = 0; i < 256; i++) send_byte(8'($urandom), 4'd0);
      drain();
      no_bubble = 1'b0;
      check("wrap_count", byte_count, 0);

      // Random traffic with random ctrl and random backpressure
      rand_mode = 1'b1;
      for (int i = 0; i < 80; i++) begin
         send_byte(8'($urandom), 4'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end
      rand_mode = 1'b0;
      nib_ready = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
